prio_encoder_8to3: RTL and testbench
====================================

PRIO_ENCODER_8TO3 -- requirements
Module: prio_encoder_8to3

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 request lines and a 3-bit code.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  level request lines; bit 7 is highest priority, bit 0 lowest.
REQ-005 ack  input  1  consumer accepts the current code when ack=1 and valid=1 at a rising edge.
REQ-006 code  output  3  binary index of the served request; valid only while valid=1.
REQ-007 valid  output  1  code holds an unacknowledged request.
REQ-008 pending  output  8  registered sticky request bits not yet loaded into code.

Function
REQ-009 Each cycle, pending SHALL update as pending_next = (pending & ~clr) | req, where clr is the one-hot bit loaded into code that cycle (zero if no load).
REQ-010 If req[i]=1 in the same cycle that bit i is cleared by a load, set SHALL win and pending[i] SHALL be 1 next cycle.
REQ-011 FSM states SHALL be IDLE (valid=0) and HOLD (valid=1).
REQ-012 IDLE: if pending != 0, the block SHALL load code = index of the highest set pending bit, clear that bit, set valid=1, and go to HOLD; otherwise it SHALL stay in IDLE.
REQ-013 Latency SHALL be 2 cycles: req sampled at edge N sets pending at N; valid/code appear after edge N+1.
REQ-014 HOLD with ack=0: code and valid SHALL remain stable; pending SHALL keep accumulating.
REQ-015 HOLD with ack=1 and pending != 0: the block SHALL load the next highest pending index in the same cycle, with valid held at 1 and no bubble.
REQ-016 HOLD with ack=1 and pending == 0: valid SHALL drop to 0 and the FSM SHALL return to IDLE.
REQ-017 ack while valid=0 SHALL be ignored.
REQ-018 Priority selection SHALL use only pending as registered at that edge; requests arriving that cycle SHALL compete from the next cycle.
REQ-019 A continuously asserted req bit SHALL be re-served after every acknowledge; starvation of lower bits is accepted behaviour.

Reset
REQ-020 On rst=1, pending, code, and valid SHALL go to 0 and the FSM to IDLE immediately, independent of clk.
REQ-021 A reset mid-transaction SHALL discard all pending and in-flight requests; nothing SHALL be replayed after release.
REQ-022 The first load SHALL occur no earlier than the second rising edge after rst deasserts with req held.

Configuration
REQ-023 When macro PRIO_ENC_ONEHOT_EN is defined, an output onehot[7:0] SHALL exist equal to (1 << code) when valid=1, else 8'h00, registered with code.
REQ-024 When PRIO_ENC_ONEHOT_EN is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Shared package prio_enc_pkg SHALL hold localparams N_REQ=8 and CODE_W=3 and the enum state_t {IDLE, HOLD}.
REQ-026 The highest-set-bit search SHALL be a combinational sub-module prio_find8 (in[7:0] -> idx[2:0], any); all state SHALL stay in the top module.

Verification
REQ-027 Single request: req=8'h10 for 1 cycle, ack=1 -> valid high 2 cycles after req with code=3'd4, then valid=0 and pending=0.
REQ-028 Priority: req=8'h85 for 1 cycle, ack=1 -> codes 7, 2, 0 on consecutive cycles, then valid=0.
REQ-029 Backpressure: req=8'h03, ack=0 for 5 cycles -> code=1 stable and pending=8'h01; after ack pulse -> code=0.
REQ-030 Set-wins: req[5] held high, ack=1 -> code=5 every cycle, valid never drops.
REQ-031 Reset mid-operation: pending=8'hF0, valid=1, async rst pulse between edges -> valid=0, pending=0, code=0 immediately; no output after release with req=0.
REQ-032 With PRIO_ENC_ONEHOT_EN: req=8'h08 -> onehot=8'h08 while valid, 8'h00 after ack.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants and FSM state type for the 8-to-3 priority encoder.
package prio_enc_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/prio_find8.sv
// Combinational highest-set-bit search over 8 lines: bit 7 wins, any flags a non-zero input.
module prio_find8
    import prio_enc_pkg::*;
(
    input  logic [N_REQ-1:0]  in,
    output logic [CODE_W-1:0] idx,
    output logic              any
);
    // Scan upward so the last (highest) set bit overwrites lower matches.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign any = |in;
endmodule

// File: rtl/prio_encoder_8to3.sv
// Sticky-request priority encoder with valid/ack handshake; optional onehot output
// is enabled by defining PRIO_ENC_ONEHOT_EN.
module prio_encoder_8to3
    import prio_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pending
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    output logic [N_REQ-1:0]  onehot
`endif
);
    state_t            state_q;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;
    logic [N_REQ-1:0]  pending_q;
    logic [N_REQ-1:0]  pending_d;
    logic [N_REQ-1:0]  clr;
    logic [CODE_W-1:0] find_idx;
    logic              find_any;
    logic              load;

    prio_find8 u_find (
        .in  (pending_q),
        .idx (find_idx),
        .any (find_any)
    );

    // Selection sees only registered pending; a same-cycle req re-sets the cleared bit.
    always_comb begin
        load      = find_any && ((state_q == IDLE) || ack);
        clr       = load ? (N_REQ'(1) << find_idx) : '0;
        pending_d = (pending_q & ~clr) | req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (find_any) begin
                        code_q  <= find_idx;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        if (find_any) begin
                            code_q <= find_idx;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PRIO_ENC_ONEHOT_EN
    logic [N_REQ-1:0] onehot_q;

    // Tracks code_q/valid_q exactly: updated on every load, cleared when valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_q <= '0;
        end else if (load) begin
            onehot_q <= N_REQ'(1) << find_idx;
        end else if (state_q == HOLD && ack) begin
            onehot_q <= '0;
        end
    end

    assign onehot = onehot_q;
`endif

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Scoreboard testbench for prio_encoder_8to3; define PRIO_ENC_ONEHOT_EN to cover the onehot output.
module tb_prio_encoder_8to3;
    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [7:0] onehot;
`endif

    int         n_checks;
    int         n_fail;
    logic [2:0] exp_q[$];
    logic [2:0] exp_code;

    prio_encoder_8to3 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending)
`ifdef PRIO_ENC_ONEHOT_EN
        ,
        .onehot  (onehot)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b code=%0d pending=%h, expected 0/0/00", valid, code, pending);
        end
        req = 8'h01;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_first_edge: got valid=%b pending=%h, expected 0/01", valid, pending);
        end
        req = 8'h00;
        ack = 1'b1;
        exp_q.push_back(3'd0);
        @(negedge clk);
        n_checks++;
        exp_code = exp_q.pop_front();
        if (valid !== 1'b1 || code !== exp_code) begin
            n_fail++;
            $display("FAIL reset_second_edge: got valid=%b code=%0d, expected 1/%0d", valid, code, exp_code);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_drain: got valid=%b pending=%h, expected 0/00", valid, pending);
        end
        $display("txn reset: done");
    endtask

    task automatic test_single();
        req = 8'h10;
        ack = 1'b1;
        exp_q.push_back(3'd4);
        @(negedge clk);
        req = 8'h00;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h10) begin
            n_fail++;
            $display("FAIL single_pending: got valid=%b pending=%h, expected 0/10", valid, pending);
        end
        @(negedge clk);
        n_checks++;
        exp_code = exp_q.pop_front();
        if (valid !== 1'b1 || code !== exp_code) begin
            n_fail++;
            $display("FAIL single_code: got valid=%b code=%0d, expected 1/%0d", valid, code, exp_code);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_drop: got valid=%b pending=%h, expected 0/00", valid, pending);
        end
        $display("txn single: req=10 code=%0d", exp_code);
    endtask

    task automatic test_priority();
        req = 8'h85;
        ack = 1'b1;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd0);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            exp_code = exp_q.pop_front();
            if (valid !== 1'b1 || code !== exp_code) begin
                n_fail++;
                $display("FAIL priority_code%0d: got valid=%b code=%0d, expected 1/%0d", k, valid, code, exp_code);
            end
            $display("txn priority: step %0d code=%0d", k, code);
            @(negedge clk);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL priority_drop: got valid=%b, expected 0", valid);
        end
    endtask

    task automatic test_backpressure();
        req = 8'h03;
        ack = 1'b0;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (valid !== 1'b1 || code !== exp_q[0] || pending !== 8'h01) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got valid=%b code=%0d pending=%h, expected 1/%0d/01", k, valid, code, pending, exp_q[0]);
            end
            @(negedge clk);
        end
        exp_code = exp_q.pop_front();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_checks++;
        exp_code = exp_q.pop_front();
        if (valid !== 1'b1 || code !== exp_code || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL backpressure_next: got valid=%b code=%0d pending=%h, expected 1/%0d/00", valid, code, pending, exp_code);
        end
        ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_drop: got valid=%b, expected 0", valid);
        end
        $display("txn backpressure: held code=1 then code=0");
    endtask

    task automatic test_set_wins();
        req = 8'h20;
        ack = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(3'd5);
            @(negedge clk);
            n_checks++;
            exp_code = exp_q.pop_front();
            if (valid !== 1'b1 || code !== exp_code || pending !== 8'h20) begin
                n_fail++;
                $display("FAIL set_wins%0d: got valid=%b code=%0d pending=%h, expected 1/%0d/20", k, valid, code, pending, exp_code);
            end
        end
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || code !== 3'd5 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL set_wins_last: got valid=%b code=%0d pending=%h, expected 1/5/00", valid, code, pending);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL set_wins_drop: got valid=%b, expected 0", valid);
        end
        $display("txn set_wins: req[5] held, code=5 each cycle");
    endtask

    task automatic test_reset_mid();
        req = 8'hF0;
        ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req = 8'h00;
        n_checks++;
        if (valid !== 1'b1 || code !== 3'd7 || pending !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got valid=%b code=%0d pending=%h, expected 1/7/F0", valid, code, pending);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_async: got valid=%b code=%0d pending=%h, expected 0/0/00", valid, code, pending);
        end
        #1 rst = 1'b0;
        exp_q.delete();
        ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || pending !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mid_replay%0d: got valid=%b pending=%h, expected 0/00", k, valid, pending);
            end
        end
        $display("txn reset_mid: outputs cleared, no replay");
    endtask

`ifdef PRIO_ENC_ONEHOT_EN
    task automatic test_onehot();
        req = 8'h08;
        ack = 1'b0;
        exp_q.push_back(3'd3);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        exp_code = exp_q.pop_front();
        if (valid !== 1'b1 || code !== exp_code || onehot !== 8'h08) begin
            n_fail++;
            $display("FAIL onehot_valid: got valid=%b code=%0d onehot=%h, expected 1/%0d/08", valid, code, onehot, exp_code);
        end
        ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || onehot !== 8'h00) begin
            n_fail++;
            $display("FAIL onehot_clear: got valid=%b onehot=%h, expected 0/00", valid, onehot);
        end
        $display("txn onehot: req=08 onehot=08 then 00");
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 8'h00;
        ack      = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_set_wins();
        test_reset_mid();
`ifdef PRIO_ENC_ONEHOT_EN
        test_onehot();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
